// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg
// Shared types for the SPI master arbiter: the FSM state encoding, the
// requester id used to steer grants and done pulses, and the command width.
// No ports; imported by spi_arb_if and spi_arb.
package spi_arb_pkg;

   localparam int CMD_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      GAP  = 2'd2
   } state_t;

   typedef enum logic {
      REQ_IMU = 1'b0,
      REQ_AUX = 1'b1
   } req_id_t;

endpackage

// File: rtl/spi_arb_if.sv
// spi_arb_if
// Bundles the two requester handshakes and the SPI master hookup that the
// arbiter sits between.
//   master modport : the arbiter's view (takes requests and master results,
//                    drives grants, done/err pulses, wrt/cmd and busy)
//   slave modport  : the surrounding logic's view (requesters + SPI master)
// Signals:
//   req0/cmd0, req1/cmd1   requests and command words
//   gnt0/gnt1, done0/done1 ownership and completion pulses
//   err, rd_data           timeout flag and response word
//   wrt, cmd               start pulse and command to the SPI master
//   mst_done, mst_rd_data  SPI master completion and received word
//   busy                   arbiter not idle
interface spi_arb_if;
   import spi_arb_pkg::*;

   logic             req0;
   logic [CMD_W-1:0] cmd0;
   logic             req1;
   logic [CMD_W-1:0] cmd1;
   logic             gnt0;
   logic             gnt1;
   logic             done0;
   logic             done1;
   logic             err;
   logic [CMD_W-1:0] rd_data;
   logic             wrt;
   logic [CMD_W-1:0] cmd;
   logic             mst_done;
   logic [CMD_W-1:0] mst_rd_data;
   logic             busy;

   modport master (
      input  req0, cmd0, req1, cmd1, mst_done, mst_rd_data,
      output gnt0, gnt1, done0, done1, err, rd_data, wrt, cmd, busy
   );

   modport slave (
      output req0, cmd0, req1, cmd1, mst_done, mst_rd_data,
      input  gnt0, gnt1, done0, done1, err, rd_data, wrt, cmd, busy
   );

endinterface

// File: rtl/spi_arb.sv
// spi_arb
// Shares the single 16-bit SPI master between the IMU sequencer (req0) and
// the auxiliary config/diagnostic port (req1). One transaction at a time,
// a fixed idle gap after each one (keeps SS_n high long enough), and a
// timeout that aborts a transfer the master never finishes.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset (shared with the SPI master)
//   bus    spi_arb_if.master: requests, grants, done/err, wrt/cmd to the
//          master, master completion/data, busy
// Parameters:
//   GAP_CYC     idle clocks after every transaction (1..255)
//   TIMEOUT     clocks allowed in XFER before abort
//   MAX_STARVE  req0 grants tolerated while req1 waits (STARVE_GUARD_EN only)
// Build option:
//   STARVE_GUARD_EN  when defined, req1 is forced through after MAX_STARVE
//                    consecutive req0 grants that it sat waiting for;
//                    otherwise req0 has strict priority.
module spi_arb
   import spi_arb_pkg::*;
#(
   parameter int GAP_CYC    = 4,
   parameter int TIMEOUT    = 1024
`ifdef STARVE_GUARD_EN
   ,
   parameter int MAX_STARVE = 8
`endif
) (
   input  logic      clk,
   input  logic      rst_n,
   spi_arb_if.master bus
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
   // The gap counter counts GAP_CYC-1 down to 0 so GAP lasts exactly GAP_CYC
   // clocks, giving done -> next wrt of GAP_CYC+1 clocks.
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC - 1);

   state_t           state;
   state_t           state_next;
   req_id_t          owner;
   req_id_t          grant_id;
   logic             grant;
   logic             finish;
   logic             timed_out;
   logic             pick_aux;
   logic [TW-1:0]    to_cnt;
   logic [GW-1:0]    gap_cnt;
   logic [CMD_W-1:0] cmd_q;
   logic [CMD_W-1:0] rd_data_q;
   logic             wrt_q;
   logic             done0_q;
   logic             done1_q;
   logic             err_q;

`ifdef STARVE_GUARD_EN
   localparam int SW = $clog2(MAX_STARVE + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(MAX_STARVE);

   logic [SW-1:0] starve_cnt;

   // Once req0 has won STARVE_LIM times in a row over a waiting req1, the
   // next arbitration goes to req1 regardless of req0.
   assign pick_aux = bus.req1 && (!bus.req0 || (starve_cnt == STARVE_LIM));

   // Count req0 wins that happened while req1 was waiting. Any req1 win, or
   // an arbitration where req1 was not asking, starts the count over.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (grant) begin
         if ((grant_id == REQ_AUX) || !bus.req1) begin
            starve_cnt <= '0;
         end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end
   end
`else
   // Strict priority: req1 only wins when req0 is not asking.
   assign pick_aux = bus.req1 && !bus.req0;
`endif

   // State register for the IDLE -> XFER -> GAP -> IDLE loop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode. In IDLE any request produces a grant; in XFER the
   // master's done takes precedence over the timeout when both land in the
   // same clock; GAP just waits out its counter.
   always_comb begin
      state_next = state;
      grant      = 1'b0;
      grant_id   = REQ_IMU;
      finish     = 1'b0;
      timed_out  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               grant      = 1'b1;
               grant_id   = pick_aux ? REQ_AUX : REQ_IMU;
               state_next = XFER;
            end
         end
         XFER: begin
            if (bus.mst_done) begin
               finish     = 1'b1;
               state_next = GAP;
            end else if (to_cnt == TO_LAST) begin
               finish     = 1'b1;
               timed_out  = 1'b1;
               state_next = GAP;
            end
         end
         GAP: begin
            if (gap_cnt == '0) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: latch the winner and its command on a grant, pulse wrt the
   // following clock, run the timeout counter through XFER, capture the
   // response (or zero on timeout) with the done pulse, then run the gap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         owner     <= REQ_IMU;
         cmd_q     <= '0;
         rd_data_q <= '0;
         wrt_q     <= 1'b0;
         done0_q   <= 1'b0;
         done1_q   <= 1'b0;
         err_q     <= 1'b0;
         to_cnt    <= '0;
         gap_cnt   <= '0;
      end else begin
         wrt_q   <= grant;
         done0_q <= finish && (owner == REQ_IMU);
         done1_q <= finish && (owner == REQ_AUX);
         err_q   <= timed_out;

         if (grant) begin
            owner  <= grant_id;
            cmd_q  <= (grant_id == REQ_AUX) ? bus.cmd1 : bus.cmd0;
            to_cnt <= '0;
         end else if (state == XFER) begin
            to_cnt <= to_cnt + 1'b1;
         end

         if (finish) begin
            rd_data_q <= timed_out ? '0 : bus.mst_rd_data;
            gap_cnt   <= GAP_LOAD;
         end else if ((state == GAP) && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - 1'b1;
         end
      end
   end

   // Grants follow the state directly so they fall in the done-pulse clock,
   // when the state has already moved on to GAP.
   assign bus.gnt0    = (state == XFER) && (owner == REQ_IMU);
   assign bus.gnt1    = (state == XFER) && (owner == REQ_AUX);
   assign bus.done0   = done0_q;
   assign bus.done1   = done1_q;
   assign bus.err     = err_q;
   assign bus.rd_data = rd_data_q;
   assign bus.wrt     = wrt_q;
   assign bus.cmd     = cmd_q;
   assign bus.busy    = (state != IDLE);

endmodule
